// File: rtl/custom_reg_bank.sv
// Hardware-side shadow of NUM_REGS software registers with an in-order write-event FIFO.
// Optional macro CUSTOM_REG_BANK_CHANGE_ONLY_EN: only value-changing software writes notify.
module custom_reg_bank #(
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_i,
  input  logic [NUM_REGS-1:0]            reg_qe_i,
  input  logic [NUM_REGS-1:0]            hw_we_i,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wdata_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] hw_d_o,
  output logic [NUM_REGS-1:0]            hw_de_o,
  output logic                           evt_valid_o,
  input  logic                           evt_ready_i,
  output logic [IdxW-1:0]                evt_idx_o,
  output logic [DATA_WIDTH-1:0]          evt_data_o,
  output logic [CntW-1:0]                evt_count_o,
  output logic                           evt_overflow_o,
  input  logic                           clear_overflow_i
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   hw_de_q, hw_de_d;

  logic [IdxW-1:0]       mem_idx_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  ovf_q;

  logic [IdxW-1:0]       push_idx;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push_req, multi_qe, full, pop, push, drop;

  // Register next state: software strobe has priority over hardware strobe.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i]  = regs_q[i];
      hw_de_d[i] = 1'b0;
      if (reg_qe_i[i]) begin
        regs_d[i] = reg_q_i[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef CUSTOM_REG_BANK_CHANGE_ONLY_EN
        hw_de_d[i] = (reg_q_i[i*DATA_WIDTH +: DATA_WIDTH] != regs_q[i]);
`else
        hw_de_d[i] = 1'b1;
`endif
      end else if (hw_we_i[i]) begin
        regs_d[i]  = hw_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        hw_de_d[i] = 1'b1;
      end
    end
  end

  // Lowest set strobe wins the single enqueue slot; scan downwards so it is assigned last.
  always_comb begin
    push_idx  = '0;
    push_data = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (reg_qe_i[i]) begin
        push_idx  = IdxW'(i);
        push_data = reg_q_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    multi_qe = |(reg_qe_i & (reg_qe_i - NUM_REGS'(1)));
    push_req = |reg_qe_i;
`ifdef CUSTOM_REG_BANK_CHANGE_ONLY_EN
    push_req = push_req && (push_data != regs_q[push_idx]);
`endif
    full  = (count_q == CntFull);
    pop   = evt_valid_o && evt_ready_i;
    push  = push_req && (!full || pop);
    drop  = push_req && full && !pop;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
      hw_de_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      hw_de_q <= hw_de_d;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_idx_q[i]  <= '0;
        mem_data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_idx_q[wr_ptr_q]  <= push_idx;
        mem_data_q[wr_ptr_q] <= push_data;
        wr_ptr_q             <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
      if (multi_qe || drop) begin
        ovf_q <= 1'b1;
      end else if (clear_overflow_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      hw_d_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  assign hw_de_o        = hw_de_q;
  assign evt_valid_o    = (count_q != '0);
  assign evt_idx_o      = evt_valid_o ? mem_idx_q[rd_ptr_q] : '0;
  assign evt_data_o     = evt_valid_o ? mem_data_q[rd_ptr_q] : '0;
  assign evt_count_o    = count_q;
  assign evt_overflow_o = ovf_q;

endmodule

// File: tb/tb_custom_reg_bank.sv
// Scoreboard bench for custom_reg_bank: stimulus queues expected events, a monitor checks pops.
module tb_custom_reg_bank;

  localparam int NR = 4;
  localparam int DW = 32;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [NR*DW-1:0] reg_q_i, hw_wdata_i, hw_d_o;
  logic [NR-1:0]   reg_qe_i, hw_we_i, hw_de_o;
  logic            evt_valid_o, evt_ready_i, evt_overflow_o, clear_overflow_i;
  logic [1:0]      evt_idx_o;
  logic [DW-1:0]   evt_data_o;
  logic [2:0]      evt_count_o;

  custom_reg_bank dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .reg_q_i          (reg_q_i),
    .reg_qe_i         (reg_qe_i),
    .hw_we_i          (hw_we_i),
    .hw_wdata_i       (hw_wdata_i),
    .hw_d_o           (hw_d_o),
    .hw_de_o          (hw_de_o),
    .evt_valid_o      (evt_valid_o),
    .evt_ready_i      (evt_ready_i),
    .evt_idx_o        (evt_idx_o),
    .evt_data_o       (evt_data_o),
    .evt_count_o      (evt_count_o),
    .evt_overflow_o   (evt_overflow_o),
    .clear_overflow_i (clear_overflow_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passes = 0;
  logic [33:0] exp_q[$];  // {idx, data}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] reg_val(input int i);
    return hw_d_o[i*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    reg_qe_i = '0;
    hw_we_i = '0;
    clear_overflow_i = 1'b0;
  endtask

  task automatic set_sw(input int i, input logic [DW-1:0] d);
    reg_qe_i[i] = 1'b1;
    reg_q_i[i*DW +: DW] = d;
  endtask

  // Monitor: every accepted head must match the oldest expected event.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && evt_valid_o && evt_ready_i) begin
        check("pop_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pop_idx", 64'(evt_idx_o), 64'(e[33:32]));
          check("pop_data", 64'(evt_data_o), 64'(e[31:0]));
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    reg_q_i = '0;
    hw_wdata_i = '0;
    evt_ready_i = 1'b0;
    idle();
    #3;
    check("rst_hw_d", 64'(hw_d_o != '0), 64'd0);
    check("rst_hw_de", 64'(hw_de_o), 64'd0);
    check("rst_valid", 64'(evt_valid_o), 64'd0);
    check("rst_count", 64'(evt_count_o), 64'd0);
    check("rst_ovf", 64'(evt_overflow_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // 1: single software write
    set_sw(1, 32'hDEADBEEF);
    exp_q.push_back({2'd1, 32'hDEADBEEF});
    tick();
    idle();
    @(negedge clk_i);
    check("t1_reg1", 64'(reg_val(1)), 64'hDEADBEEF);
    check("t1_de", 64'(hw_de_o), 64'b0010);
    check("t1_valid", 64'(evt_valid_o), 64'd1);
    check("t1_idx", 64'(evt_idx_o), 64'd1);
    check("t1_data", 64'(evt_data_o), 64'hDEADBEEF);
    tick();
    check("t1_de_off", 64'(hw_de_o), 64'd0);
    evt_ready_i = 1'b1;
    tick();
    evt_ready_i = 1'b0;
    check("t1_empty", 64'(evt_valid_o), 64'd0);

    // 2: software beats hardware in the same cycle
    set_sw(2, 32'h11);
    hw_we_i[2] = 1'b1;
    hw_wdata_i[2*DW +: DW] = 32'h22;
    exp_q.push_back({2'd2, 32'h11});
    tick();
    idle();
    check("t2_reg2", 64'(reg_val(2)), 64'h11);
    check("t2_count", 64'(evt_count_o), 64'd1);
    evt_ready_i = 1'b1;
    tick();
    evt_ready_i = 1'b0;
    check("t2_count0", 64'(evt_count_o), 64'd0);

    // hardware-only write: pulses de, no event
    hw_we_i[3] = 1'b1;
    hw_wdata_i[3*DW +: DW] = 32'h33;
    tick();
    idle();
    check("hw_reg3", 64'(reg_val(3)), 64'h33);
    check("hw_de", 64'(hw_de_o), 64'b1000);
    check("hw_noevt", 64'(evt_count_o), 64'd0);

    // 3: overfill the FIFO, fifth write dropped
    for (int v = 1; v <= 5; v++) begin
      set_sw(0, 32'(v));
      if (v <= 4) exp_q.push_back({2'd0, 32'(v)});
      tick();
    end
    idle();
    check("t3_de_cont", 64'(hw_de_o), 64'b0001);
    check("t3_count", 64'(evt_count_o), 64'd4);
    check("t3_ovf", 64'(evt_overflow_o), 64'd1);
    clear_overflow_i = 1'b1;
    tick();
    idle();
    check("t3_ovf_clr", 64'(evt_overflow_o), 64'd0);

    // 4: full FIFO, simultaneous pop and push
    evt_ready_i = 1'b1;
    set_sw(3, 32'hA5);
    exp_q.push_back({2'd3, 32'hA5});
    tick();
    idle();
    check("t4_count", 64'(evt_count_o), 64'd4);
    check("t4_ovf", 64'(evt_overflow_o), 64'd0);
    repeat (4) tick();
    evt_ready_i = 1'b0;
    check("t4_empty", 64'(evt_valid_o), 64'd0);
    check("t4_count0", 64'(evt_count_o), 64'd0);
    tick();
    check("t4_no_underflow", 64'(evt_count_o), 64'd0);

    // 5: two strobes at once
    set_sw(1, 32'h1111);
    set_sw(2, 32'h2222);
    exp_q.push_back({2'd1, 32'h1111});
    tick();
    idle();
    check("t5_reg1", 64'(reg_val(1)), 64'h1111);
    check("t5_reg2", 64'(reg_val(2)), 64'h2222);
    check("t5_de", 64'(hw_de_o), 64'b0110);
    check("t5_count", 64'(evt_count_o), 64'd1);
    check("t5_ovf", 64'(evt_overflow_o), 64'd1);
    clear_overflow_i = 1'b1;
    tick();
    idle();
    check("t5_ovf_clr", 64'(evt_overflow_o), 64'd0);
    // set beats clear
    clear_overflow_i = 1'b1;
    set_sw(0, 32'hC0);
    set_sw(1, 32'hC1);
    exp_q.push_back({2'd0, 32'hC0});
    tick();
    idle();
    check("t5_set_wins", 64'(evt_overflow_o), 64'd1);

    // 6: asynchronous reset with three queued events
    set_sw(3, 32'h3333);
    exp_q.push_back({2'd3, 32'h3333});
    tick();
    idle();
    check("t6_count3", 64'(evt_count_o), 64'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_count", 64'(evt_count_o), 64'd0);
    check("t6_valid", 64'(evt_valid_o), 64'd0);
    check("t6_regs", 64'(hw_d_o != '0), 64'd0);
    check("t6_ovf", 64'(evt_overflow_o), 64'd0);
    exp_q.delete();
    tick();
    rst_ni = 1'b1;
    tick();

    // repeated identical write
    set_sw(0, 32'h77);
    exp_q.push_back({2'd0, 32'h77});
    tick();
    set_sw(0, 32'h77);
`ifndef CUSTOM_REG_BANK_CHANGE_ONLY_EN
    exp_q.push_back({2'd0, 32'h77});
`endif
    tick();
    idle();
`ifdef CUSTOM_REG_BANK_CHANGE_ONLY_EN
    check("same_count", 64'(evt_count_o), 64'd1);
    check("same_de", 64'(hw_de_o), 64'd0);
`else
    check("same_count", 64'(evt_count_o), 64'd2);
    check("same_de", 64'(hw_de_o), 64'b0001);
`endif
    evt_ready_i = 1'b1;
    repeat (4) tick();
    evt_ready_i = 1'b0;
    check("final_empty", 64'(evt_valid_o), 64'd0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
